// File: rtl/tx_ofdm_pkg.sv
// Shared constants, types and helpers for the OFDM transmit data path.
//
// Contents:
//   SERVICE_BITS / TAIL_BITS   - field lengths of the serial DATA stream
//   SCRAM_DEFAULT_SEED         - scrambler seed used when the supplied seed is 0
//   SCRAM_TAP_HI / SCRAM_TAP_LO - feedback taps of the x^7 + x^4 + 1 scrambler
//   scram_state_e              - scrambler control states
//   tail_start()               - bit index of the first tail bit for a PSDU length
package tx_ofdm_pkg;

    localparam int unsigned SERVICE_BITS = 16;
    localparam int unsigned TAIL_BITS    = 6;

    localparam int unsigned LFSR_W = 7;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned PLEN_W = 16;

    localparam logic [LFSR_W-1:0] SCRAM_DEFAULT_SEED = 7'b1011101;

    localparam int unsigned SCRAM_TAP_HI = 6;
    localparam int unsigned SCRAM_TAP_LO = 3;

    typedef enum logic {
        IDLE,
        SCRAMBLE
    } scram_state_e;

    // 16 + 8*plen evaluated at CNT_W bits; the largest result (524296) fits, so no wrap.
    function automatic logic [CNT_W-1:0] tail_start(input logic [PLEN_W-1:0] plen);
        return CNT_W'(SERVICE_BITS) + {{(CNT_W - PLEN_W - 3){1'b0}}, plen, 3'b000};
    endfunction

endpackage

// File: rtl/tx_data_scrambler_if.sv
// Serial bit-stream bundle between the data/pad generator, the scrambler and
// the downstream encoder.
//
// Signals:
//   data_bit_valid  - input bit qualifier; one frame is one contiguous high run
//   data_bit        - serial input bit (SERVICE + PSDU + tail + pad)
//   packetlength    - PSDU length in bytes, held stable for a frame
//   scram_seed      - initial scrambler state, 0 selects the default seed
//   scram_bit_valid - scrambled bit qualifier
//   scram_bit       - scrambled bit
//   frame_done      - one-cycle pulse after the last scrambled bit of a frame
//
// Modports:
//   master - the stream source / sink side (drives data, observes results)
//   slave  - the scrambler itself
interface tx_data_scrambler_if
    import tx_ofdm_pkg::*;
;

    logic                  data_bit_valid;
    logic                  data_bit;
    logic [PLEN_W-1:0]     packetlength;
    logic [LFSR_W-1:0]     scram_seed;
    logic                  scram_bit_valid;
    logic                  scram_bit;
    logic                  frame_done;

    modport master (
        output data_bit_valid,
        output data_bit,
        output packetlength,
        output scram_seed,
        input  scram_bit_valid,
        input  scram_bit,
        input  frame_done
    );

    modport slave (
        input  data_bit_valid,
        input  data_bit,
        input  packetlength,
        input  scram_seed,
        output scram_bit_valid,
        output scram_bit,
        output frame_done
    );

endinterface

// File: rtl/scrambler_lfsr7.sv
// Seven-bit Fibonacci LFSR for the x^7 + x^4 + 1 data scrambler.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset, state returns to RESET_SEED
//   load     - take 'seed' as the current state this cycle
//   seed     - state to use when 'load' is high
//   advance  - shift once this cycle
//   fb       - feedback bit of the current state (the keystream bit)
//   state    - registered LFSR state
//
// When 'load' is high the feedback is computed from 'seed' directly, so the
// first bit of a frame is scrambled with the freshly loaded seed in the same
// cycle it is loaded.
module scrambler_lfsr7
    import tx_ofdm_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = SCRAM_DEFAULT_SEED
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic              fb,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] lfsr_cur;

    assign lfsr_cur = load ? seed : lfsr_q;
    assign fb       = lfsr_cur[SCRAM_TAP_HI] ^ lfsr_cur[SCRAM_TAP_LO];

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {lfsr_cur[LFSR_W-2:0], fb};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= RESET_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/tx_data_scrambler.sv
// OFDM transmit data scrambler.
//
// Scrambles the serial DATA field (SERVICE + PSDU + tail + pad) with the
// x^7 + x^4 + 1 sequence, forces the six tail bits that follow the PSDU to
// zero, and flags the end of each frame. Output follows input by one cycle.
//
// Ports:
//   clk_Modulation - bit-rate clock, rising edge
//   reset_n        - asynchronous active-low reset
//   bus_io         - serial stream bundle (slave side), see tx_data_scrambler_if
//
// Parameters:
//   DEFAULT_SEED   - seed used when bus_io.scram_seed is 0, and the LFSR reset value
module tx_data_scrambler
    import tx_ofdm_pkg::*;
#(
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = SCRAM_DEFAULT_SEED
) (
    input  logic                clk_Modulation,
    input  logic                reset_n,
    tx_data_scrambler_if.slave  bus_io
);

    scram_state_e      state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              scram_bit_valid_q;
    logic              scram_bit_q;
    logic              frame_done_q;

    logic              frame_start;
    logic [LFSR_W-1:0] seed_eff;
    logic [CNT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  tail_first;
    logic              in_tail;
    logic              lfsr_fb;
    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr_state;

    assign frame_start = (state_q == IDLE) && bus_io.data_bit_valid;
    assign seed_eff    = (bus_io.scram_seed == '0) ? DEFAULT_SEED : bus_io.scram_seed;

    // Index of the bit presented this cycle; the first bit of a frame is bit 0
    // regardless of what the counter held from the previous frame.
    assign bit_idx    = frame_start ? '0 : bit_cnt_q;
    assign tail_first = tail_start(bus_io.packetlength);
    // Unsigned difference keeps the window test free of an extra adder carry.
    assign in_tail    = (bit_idx >= tail_first) &&
                        ((bit_idx - tail_first) < CNT_W'(TAIL_BITS));

    scrambler_lfsr7 #(
        .RESET_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk_i   (clk_Modulation),
        .rst_ni  (reset_n),
        .load    (frame_start),
        .seed    (seed_eff),
        .advance (bus_io.data_bit_valid),
        .fb      (lfsr_fb),
        .state   (lfsr_state)
    );

    // The raw LFSR state is only of interest when probing the design.
    assign unused_lfsr_state = ^lfsr_state;

    always_ff @(posedge clk_Modulation or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            bit_cnt_q         <= '0;
            scram_bit_valid_q <= 1'b0;
            scram_bit_q       <= 1'b0;
            frame_done_q      <= 1'b0;
        end else begin
            scram_bit_valid_q <= bus_io.data_bit_valid;
            // Gated by valid so the output bit idles at 0.
            scram_bit_q       <= bus_io.data_bit_valid & ~in_tail &
                                 (bus_io.data_bit ^ lfsr_fb);
            frame_done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus_io.data_bit_valid) begin
                        state_q   <= SCRAMBLE;
                        bit_cnt_q <= bit_idx + CNT_W'(1);
                    end
                end
                SCRAMBLE: begin
                    if (bus_io.data_bit_valid) begin
                        bit_cnt_q <= bit_idx + CNT_W'(1);
                    end else begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_io.scram_bit_valid = scram_bit_valid_q;
    assign bus_io.scram_bit       = scram_bit_q;
    assign bus_io.frame_done      = frame_done_q;

endmodule

// File: tb/tb_tx_data_scrambler.sv
// Self-checking bench for tx_data_scrambler: constant vector table, hand-written
// corner sequences and randomized frames checked against a keystream model.
module tb_tx_data_scrambler;

    localparam logic [6:0] DEF_SEED = 7'b1011101;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_data_scrambler_if bus ();

    tx_data_scrambler dut (
        .clk_Modulation (clk),
        .reset_n        (rst_n),
        .bus_io         (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int   cyc;
        logic b;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    logic recv_q[$];
    int   done_cnt = 0;

    logic        m_in_frame = 1'b0;
    int          m_n;
    logic [15:0] m_plen;
    logic        m_q[$];

    // Sequence q with q[0..6] = seed[6..0] and q[m] = q[m-7] ^ q[m-4];
    // keystream bit n is q[n+7].
    function automatic logic key_bit(input int n);
        while (m_q.size() < n + 8) begin
            m_q.push_back(m_q[m_q.size() - 7] ^ m_q[m_q.size() - 4]);
        end
        return m_q[n + 7];
    endfunction

    task automatic model_step(input logic v, input logic d);
        exp_t        e;
        logic [6:0]  s;
        int          ts;
        if (v) begin
            if (!m_in_frame) begin
                m_in_frame = 1'b1;
                m_n        = 0;
                m_plen     = bus.packetlength;
                s          = (bus.scram_seed == 7'd0) ? DEF_SEED : bus.scram_seed;
                m_q.delete();
                for (int i = 6; i >= 0; i--) m_q.push_back(s[i]);
            end
            ts    = 16 + 8 * int'(m_plen);
            e.cyc = cyc + 1;
            e.b   = (m_n >= ts && m_n < ts + 6) ? 1'b0 : (d ^ key_bit(m_n));
            exp_q.push_back(e);
            m_n++;
        end else if (m_in_frame) begin
            m_in_frame = 1'b0;
            done_q.push_back(cyc + 1);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic d, input logic [6:0] seed,
                         input logic [15:0] plen);
        @(posedge clk);
        #1;
        bus.data_bit_valid = v;
        bus.data_bit       = d;
        bus.scram_seed     = seed;
        bus.packetlength   = plen;
        model_step(v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), bus.scram_seed, bus.packetlength);
    endtask

    // Sends nbits of pat, MSB first, followed by one invalid cycle.
    task automatic send_frame(input logic [6:0] seed, input logic [15:0] plen, input int nbits,
                              input logic [63:0] pat, input bit noisy_seed);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, pat[nbits-1-i], (i == 0 || !noisy_seed) ? seed : 7'($urandom), plen);
        end
        drive(1'b0, 1'($urandom), seed, plen);
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst_n              = 1'b0;
        bus.data_bit_valid = 1'b0;
        exp_q.delete();
        done_q.delete();
        m_in_frame = 1'b0;
        #1;
        chk("rst_valid", bus.scram_bit_valid, 0);
        chk("rst_bit", bus.scram_bit, 0);
        chk("rst_done", bus.frame_done, 0);
        repeat (ncyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] word_at(input int base);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) if (base + i < recv_q.size()) w[15-i] = recv_q[base + i];
        return w;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.scram_bit_valid) begin
                    recv_q.push_back(bus.scram_bit);
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                        chk("scram_bit", bus.scram_bit, exp_q[0].b);
                        void'(exp_q.pop_front());
                    end else begin
                        chk("unexpected_valid", bus.scram_bit_valid, 0);
                    end
                end else begin
                    chk("bit_zero_when_invalid", bus.scram_bit, 0);
                    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                        chk("missing_valid", bus.scram_bit_valid, 1);
                        void'(exp_q.pop_front());
                    end
                end
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    chk("frame_done", bus.frame_done, 1);
                    void'(done_q.pop_front());
                end else if (bus.frame_done) begin
                    chk("unexpected_frame_done", bus.frame_done, 0);
                end
                if (bus.frame_done) done_cnt++;
            end
        end
    end

    // ---------------- test sequence ----------------
    typedef struct {
        logic [6:0]  seed;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          d0;
        logic [5:0]  tail;
        logic [15:0] plen;

        // Outputs for a 16-bit frame, first bit in the MSB.
        vecs[0] = '{seed: 7'h7F, data: 16'h0000, exp: 16'h0EF2};
        vecs[1] = '{seed: 7'h00, data: 16'h0000, exp: 16'h6C19};
        vecs[2] = '{seed: 7'h5D, data: 16'h0000, exp: 16'h6C19};
        vecs[3] = '{seed: 7'h01, data: 16'h0000, exp: 16'h1317};
        vecs[4] = '{seed: 7'h7F, data: 16'hFFFF, exp: 16'hF10D};
        vecs[5] = '{seed: 7'h01, data: 16'hFFFF, exp: 16'hECE8};
        vecs[6] = '{seed: 7'h7F, data: 16'hAAAA, exp: 16'hA458};

        rst_n              = 1'b0;
        bus.data_bit_valid = 1'b0;
        bus.data_bit       = 1'b0;
        bus.packetlength   = 16'd100;
        bus.scram_seed     = 7'h7F;
        #12;
        chk("reset_valid", bus.scram_bit_valid, 0);
        chk("reset_bit", bus.scram_bit, 0);
        chk("reset_done", bus.frame_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Constant vector table.
        for (int k = 0; k < 7; k++) begin
            recv_q.delete();
            send_frame(vecs[k].seed, 16'd100, 16, {48'd0, vecs[k].data}, 1'b0);
            idle(2);
            chk($sformatf("vec%0d_len", k), recv_q.size(), 16);
            chk($sformatf("vec%0d_word", k), word_at(0), vecs[k].exp);
        end

        // packetlength 1, 40 ones: tail at 24..29.
        recv_q.delete();
        d0 = done_cnt;
        send_frame(7'h7F, 16'd1, 40, 64'h00_0000_00FF_FFFF_FFFF, 1'b0);
        idle(2);
        chk("tail40_len", recv_q.size(), 40);
        for (int i = 0; i < 6; i++) tail[i] = (24 + i < recv_q.size()) ? recv_q[24 + i] : 1'b1;
        chk("tail40_zero", tail, 0);
        chk("tail40_head", word_at(0), 16'hF10D);
        chk("tail40_done_cnt", done_cnt - d0, 1);

        // Back-to-back frames, one-cycle gap, different seeds.
        recv_q.delete();
        d0 = done_cnt;
        send_frame(7'h7F, 16'd100, 16, 64'd0, 1'b0);
        send_frame(7'h01, 16'd100, 16, 64'd0, 1'b0);
        idle(2);
        chk("b2b_len", recv_q.size(), 32);
        chk("b2b_first", word_at(0), 16'h0EF2);
        chk("b2b_second", word_at(16), 16'h1317);
        chk("b2b_done_cnt", done_cnt - d0, 2);

        // Reset in the middle of a frame at bit 10.
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom), 7'h7F, 16'd100);
        do_reset(2);
        idle(3);
        chk("abort_no_done", done_cnt - d0, 0);
        recv_q.delete();
        send_frame(7'h7F, 16'd100, 16, 64'd0, 1'b0);
        idle(2);
        chk("after_reset_word", word_at(0), 16'h0EF2);

        // Short frame before the tail (packetlength 4, 20 bits).
        recv_q.delete();
        d0 = done_cnt;
        send_frame(7'($urandom), 16'd4, 20, {$urandom, $urandom}, 1'b0);
        idle(2);
        chk("short_len", recv_q.size(), 20);
        chk("short_done_cnt", done_cnt - d0, 1);

        // packetlength 0: tail immediately after SERVICE.
        recv_q.delete();
        send_frame(7'h7F, 16'd0, 30, 64'h3FFF_FFFF, 1'b0);
        idle(2);
        for (int i = 0; i < 6; i++) tail[i] = (16 + i < recv_q.size()) ? recv_q[16 + i] : 1'b1;
        chk("plen0_tail_zero", tail, 0);

        // Largest packetlength: tail start must not wrap into the frame.
        send_frame(7'h7F, 16'hFFFF, 24, 64'hFF_FFFF, 1'b0);
        idle(2);

        // Random frames, seed wiggled mid-frame.
        for (int f = 0; f < 30; f++) begin
            plen = 16'($urandom_range(0, 5));
            send_frame(($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom), plen,
                       $urandom_range(1, 64), {$urandom, $urandom}, 1'b1);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("exp_drained", exp_q.size(), 0);
        chk("done_drained", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_data_scrambler.md
TX_DATA_SCRAMBLER -- requirements
Module: tx_data_scrambler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, exposed as the two ports below.
REQ-002 clk_Modulation  input  1  bit-rate clock; all logic is on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 data_bit_valid  input  1  serial bit qualifier from the upstream data/pad generator; a frame is one contiguous high run.
REQ-005 data_bit  input  1  serial bit: SERVICE(16) + PSDU + tail(6) + pad.
REQ-006 packetlength  input  16  PSDU length in bytes; stable for the whole frame.
REQ-007 scram_seed  input  7  initial LFSR state; 0 selects DEFAULT_SEED.
REQ-008 scram_bit_valid  output  1  scrambled bit qualifier.
REQ-009 scram_bit  output  1  scrambled bit.
REQ-010 frame_done  output  1  one-cycle pulse on the cycle after the last scram_bit_valid of a frame.

Function
REQ-011 Parameter DEFAULT_SEED, default 7'b1011101: the seed used when scram_seed is 0.
REQ-012 The state machine SHALL have the states IDLE and SCRAMBLE.
REQ-013 IDLE->SCRAMBLE SHALL occur on the first data_bit_valid=1 cycle.
  - On that cycle, lfsr SHALL be loaded with scram_seed (or DEFAULT_SEED if the seed is 0).
  - The first bit SHALL be processed using the loaded seed.
REQ-014 SCRAMBLE->IDLE SHALL occur on the first cycle with data_bit_valid=0; frame_done pulses on the next cycle.
REQ-015 LFSR: polynomial x^7+x^4+1.
  - fb = lfsr[6]^lfsr[3].
  - Next state = {lfsr[5:0], fb}.
  - The LFSR advances exactly once per valid input bit, and never otherwise.
REQ-016 The scrambled bit SHALL be data_bit^fb.
REQ-017 Bit counter: 24 bits wide, cleared at frame start, incremented per valid bit.
  - TAIL_START = 16 + 8*packetlength, computed in 24-bit arithmetic with no overflow.
REQ-018 Tail zeroing: for counter values TAIL_START to TAIL_START+5 inclusive, scram_bit SHALL be forced to 0. The LFSR still advances on these bits.
REQ-019 Latency: scram_bit_valid/scram_bit SHALL follow data_bit_valid/data_bit by exactly 1 cycle, with no gaps inserted or removed.
REQ-020 Short frame: if a frame ends before TAIL_START+6 bits, the block SHALL output all bits received, with no stall, and return to IDLE.
REQ-021 Back-to-back frames: when valid goes low for exactly 1 cycle and then high again, the second frame SHALL reload the seed and clear the counter.
REQ-022 A scram_seed change mid-frame SHALL have no effect until the next frame start.
REQ-023 When scram_bit_valid=0, scram_bit SHALL be 0.

Reset
REQ-024 On reset_n=0:
  - state = IDLE; lfsr = DEFAULT_SEED; bit counter = 0.
  - scram_bit_valid = 0; scram_bit = 0; frame_done = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse.
REQ-026 After reset_n rises, the next valid bit SHALL be treated as a frame start.

Structure
REQ-027 Shared package tx_ofdm_pkg SHALL hold:
  - SERVICE_BITS=16, TAIL_BITS=6;
  - SCRAM_DEFAULT_SEED;
  - the tap positions 6 and 3;
  - the state enumeration.
REQ-028 The LFSR SHALL be one sub-module, scrambler_lfsr7, with ports: load, seed, advance, fb, state. The FSM, counter and tail logic stay in tx_data_scrambler.

Verification
REQ-029 Seed 7'h7F, 16 zero bits -> scram_bit = 0000111011110010, 1 cycle after input.
REQ-030 Seed 0, all-zero input -> output equals the sequence for seed 7'b1011101.
REQ-031 packetlength=1, seed 7'h7F, 40 input bits of all ones:
  - bits 24..29 of the output = 0;
  - all other bits = ~LFSR sequence;
  - frame_done is high for 1 cycle after the bit-39 output.
REQ-032 Two frames separated by a 1-cycle valid gap, with seeds 7'h7F then 7'h01 -> each frame starts its own sequence; frame_done pulses twice.
REQ-033 reset_n low for 2 cycles at bit 10 of a frame -> outputs are 0 immediately, there is no frame_done, and the next frame starts from the seed with counter 0.
REQ-034 Frame of 20 bits with packetlength=4 -> all 20 bits are output scrambled, with no zeroing; the block returns to IDLE.
